// File: rtl/uart_alu_interface_if.sv
// Bundle of UART strobes, ALU connections and sequencer outputs for uart_alu_interface.
// The master side is the sequencer; the slave side is the UART/ALU environment.
interface uart_alu_interface_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] i_rx_data;
  logic                  i_rx_done;
  logic                  i_tx_done;
  logic [DATA_WIDTH-1:0] i_alu_result;
  logic [4:0]            i_alu_flags;
  logic [DATA_WIDTH-1:0] o_operandA;
  logic [DATA_WIDTH-1:0] o_operandB;
  logic [3:0]            o_opcode;
  logic [DATA_WIDTH-1:0] o_tx_data;
  logic                  o_tx_start;
  logic                  o_busy;
  logic                  o_drop;

  modport master (
    input  i_rx_data, i_rx_done, i_tx_done, i_alu_result, i_alu_flags,
    output o_operandA, o_operandB, o_opcode, o_tx_data, o_tx_start, o_busy, o_drop
  );

  modport slave (
    output i_rx_data, i_rx_done, i_tx_done, i_alu_result, i_alu_flags,
    input  o_operandA, o_operandB, o_opcode, o_tx_data, o_tx_start, o_busy, o_drop
  );
endinterface

// File: rtl/uart_alu_interface.sv
// Sequencer that gathers operand A, operand B and opcode bytes from the UART,
// presents them to the ALU, then transmits the result byte followed by the flags byte.
module uart_alu_interface #(
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input logic                 i_clock,
  input logic                 i_reset,
  uart_alu_interface_if.master bus
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND_RES, WAIT_RES, SEND_FLG, WAIT_FLG
  } stateT;

  stateT                 stateQ;
  logic [DATA_WIDTH-1:0] operandAQ;
  logic [DATA_WIDTH-1:0] operandBQ;
  logic [3:0]            opcodeQ;
  logic [DATA_WIDTH-1:0] txDataQ;
  logic [4:0]            flagsQ;
  logic                  txStartQ;
  logic                  dropQ;
  logic [CW-1:0]         timerQ;

  // tx_start and tx_data are loaded on the edge entering SEND_*, so the pulse
  // occupies exactly the SEND_* cycle without any combinational output path.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      stateQ    <= WAIT_A;
      operandAQ <= '0;
      operandBQ <= '0;
      opcodeQ   <= '0;
      txDataQ   <= '0;
      flagsQ    <= '0;
      txStartQ  <= 1'b0;
      dropQ     <= 1'b0;
      timerQ    <= '0;
    end else begin
      txStartQ <= 1'b0;
      dropQ    <= 1'b0;
      case (stateQ)
        WAIT_A: begin
          timerQ <= '0;
          if (bus.i_rx_done) begin
            operandAQ <= bus.i_rx_data;
            stateQ    <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (bus.i_rx_done) begin
            operandBQ <= bus.i_rx_data;
            timerQ    <= '0;
            stateQ    <= WAIT_OP;
          end else if (timerQ == CW'(TIMEOUT_CYCLES - 1)) begin
            timerQ <= '0;
            stateQ <= WAIT_A;
          end else begin
            timerQ <= timerQ + CW'(1);
          end
        end
        WAIT_OP: begin
          if (bus.i_rx_done) begin
            opcodeQ <= bus.i_rx_data[3:0];
            timerQ  <= '0;
            stateQ  <= EXEC;
          end else if (timerQ == CW'(TIMEOUT_CYCLES - 1)) begin
            timerQ <= '0;
            stateQ <= WAIT_A;
          end else begin
            timerQ <= timerQ + CW'(1);
          end
        end
        EXEC: begin
          dropQ    <= bus.i_rx_done;
          flagsQ   <= bus.i_alu_flags;
          txDataQ  <= bus.i_alu_result;
          txStartQ <= 1'b1;
          stateQ   <= SEND_RES;
        end
        SEND_RES: begin
          dropQ  <= bus.i_rx_done;
          stateQ <= WAIT_RES;
        end
        WAIT_RES: begin
          dropQ <= bus.i_rx_done;
          if (bus.i_tx_done) begin
            txDataQ  <= DATA_WIDTH'(flagsQ);
            txStartQ <= 1'b1;
            stateQ   <= SEND_FLG;
          end
        end
        SEND_FLG: begin
          dropQ  <= bus.i_rx_done;
          stateQ <= WAIT_FLG;
        end
        WAIT_FLG: begin
          dropQ <= bus.i_rx_done;
          if (bus.i_tx_done) begin
            stateQ <= WAIT_A;
          end
        end
        default: stateQ <= WAIT_A;
      endcase
    end
  end

  assign bus.o_operandA = operandAQ;
  assign bus.o_operandB = operandBQ;
  assign bus.o_opcode   = opcodeQ;
  assign bus.o_tx_data  = txDataQ;
  assign bus.o_tx_start = txStartQ;
  assign bus.o_drop     = dropQ;
  assign bus.o_busy     = (stateQ != WAIT_A);

endmodule

// File: tb/tb_uart_alu_interface.sv
// Directed testbench for uart_alu_interface with a small ALU stand-in
// (ADD=8, SUB=A, AND=C, everything else raises the exception flag).
module tb_uart_alu_interface;

  localparam int DW = 8;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_alu_interface_if #(.DATA_WIDTH(DW)) bus ();

  uart_alu_interface #(
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clock(clk),
    .i_reset(rst),
    .bus    (bus)
  );

  int testsRun    = 0;
  int testsFailed = 0;

  logic [8:0] aluWide;
  logic [7:0] aluRes;
  logic [4:0] aluFlg;

  // Flags are {exception, negative, overflow, carry, zero}.
  always_comb begin
    aluWide = '0;
    aluRes  = '0;
    aluFlg  = '0;
    case (bus.o_opcode)
      4'h8: begin
        aluWide   = {1'b0, bus.o_operandA} + {1'b0, bus.o_operandB};
        aluRes    = aluWide[7:0];
        aluFlg[1] = aluWide[8];
        aluFlg[2] = (bus.o_operandA[7] == bus.o_operandB[7]) && (aluRes[7] != bus.o_operandA[7]);
      end
      4'hA: begin
        aluWide   = {1'b0, bus.o_operandA} - {1'b0, bus.o_operandB};
        aluRes    = aluWide[7:0];
        aluFlg[1] = aluWide[8];
        aluFlg[2] = (bus.o_operandA[7] != bus.o_operandB[7]) && (aluRes[7] != bus.o_operandA[7]);
      end
      4'hC: aluRes = bus.o_operandA & bus.o_operandB;
      default: aluFlg[4] = 1'b1;
    endcase
    if (!aluFlg[4]) begin
      aluFlg[3] = aluRes[7];
      aluFlg[0] = (aluRes == 8'h00);
    end
  end

  assign bus.i_alu_result = aluRes;
  assign bus.i_alu_flags  = aluFlg;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk);
    bus.i_rx_data = b;
    bus.i_rx_done = 1'b1;
    @(negedge clk);
    bus.i_rx_done = 1'b0;
  endtask

  task automatic runFrame(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] op, input logic [7:0] expRes,
                          input logic [7:0] expFlg, input bit injectDrop);
    int extraStarts;
    applyStimulus(a);
    applyStimulus(b);
    applyStimulus(op);
    checkOutput({tag, ".opcode"}, 32'(bus.o_opcode), 32'(op[3:0]));
    checkOutput({tag, ".startExec"}, 32'(bus.o_tx_start), 32'd0);
    @(negedge clk);
    checkOutput({tag, ".startRes"}, 32'(bus.o_tx_start), 32'd1);
    checkOutput({tag, ".result"}, 32'(bus.o_tx_data), 32'(expRes));
    extraStarts = 0;
    repeat (3) begin
      @(negedge clk);
      extraStarts += int'(bus.o_tx_start);
    end
    if (injectDrop) begin
      bus.i_rx_data = 8'h5A;
      bus.i_rx_done = 1'b1;
      @(negedge clk);
      bus.i_rx_done = 1'b0;
      checkOutput({tag, ".dropPulse"}, 32'(bus.o_drop), 32'd1);
      @(negedge clk);
      checkOutput({tag, ".dropEnd"}, 32'(bus.o_drop), 32'd0);
      checkOutput({tag, ".dropBusy"}, 32'(bus.o_busy), 32'd1);
    end
    bus.i_tx_done = 1'b1;
    @(negedge clk);
    bus.i_tx_done = 1'b0;
    checkOutput({tag, ".startFlg"}, 32'(bus.o_tx_start), 32'd1);
    checkOutput({tag, ".flags"}, 32'(bus.o_tx_data), 32'(expFlg));
    repeat (3) begin
      @(negedge clk);
      extraStarts += int'(bus.o_tx_start);
    end
    checkOutput({tag, ".extraStarts"}, 32'(extraStarts), 32'd0);
    checkOutput({tag, ".busyFlg"}, 32'(bus.o_busy), 32'd1);
    bus.i_tx_done = 1'b1;
    @(negedge clk);
    bus.i_tx_done = 1'b0;
    checkOutput({tag, ".idle"}, 32'(bus.o_busy), 32'd0);
    checkOutput({tag, ".holdA"}, 32'(bus.o_operandA), 32'(a));
    checkOutput({tag, ".holdB"}, 32'(bus.o_operandB), 32'(b));
    checkOutput({tag, ".holdTx"}, 32'(bus.o_tx_data), 32'(expFlg));
  endtask

  function automatic logic [31:0] allOutputs();
    return 32'({bus.o_operandA, bus.o_operandB, bus.o_opcode, bus.o_tx_data,
                bus.o_tx_start, bus.o_busy, bus.o_drop});
  endfunction

  initial begin
    rst           = 1'b1;
    bus.i_rx_data = '0;
    bus.i_rx_done = 1'b0;
    bus.i_tx_done = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset.outputs", allOutputs(), 32'd0);
    rst = 1'b0;

    // A stray tx_done while idle must not start anything.
    bus.i_tx_done = 1'b1;
    @(negedge clk);
    bus.i_tx_done = 1'b0;
    checkOutput("idleTxDone.busy", 32'(bus.o_busy), 32'd0);
    checkOutput("idleTxDone.start", 32'(bus.o_tx_start), 32'd0);

    runFrame("add",      8'h05, 8'h03, 8'h08, 8'h08, 8'h00, 1'b0);
    runFrame("addOvf",   8'h7F, 8'h01, 8'h08, 8'h80, 8'h0C, 1'b0);
    runFrame("subZero",  8'h10, 8'h10, 8'h0A, 8'h00, 8'h01, 1'b0);
    runFrame("andNib",   8'hF5, 8'h3C, 8'hAC, 8'h34, 8'h00, 1'b0);
    runFrame("undefOp",  8'h12, 8'h34, 8'h0F, 8'h00, 8'h10, 1'b1);

    applyStimulus(8'hAA);
    repeat (8) @(negedge clk);
    checkOutput("timeout.busyEarly", 32'(bus.o_busy), 32'd1);
    repeat (12) @(negedge clk);
    checkOutput("timeout.busyLate", 32'(bus.o_busy), 32'd0);
    checkOutput("timeout.keepA", 32'(bus.o_operandA), 32'hAA);
    runFrame("afterTimeout", 8'h01, 8'h02, 8'h08, 8'h03, 8'h00, 1'b0);

    applyStimulus(8'h05);
    applyStimulus(8'h03);
    applyStimulus(8'h08);
    repeat (2) @(negedge clk);
    checkOutput("midReset.busyBefore", 32'(bus.o_busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midReset.outputs", allOutputs(), 32'd0);
    runFrame("afterReset", 8'h20, 8'h22, 8'h08, 8'h42, 8'h00, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
